// File: rtl/ysyx_23060240_wbu_if.sv
// Bundle of the write-back stage's upstream handshake, LSU load return, register-file write
// and retire signals. The master drives instructions in; the slave is the write-back stage.
interface ysyx_23060240_wbu_if #(
    parameter int unsigned XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [4:0]      in_rd;
    logic            in_rd_wen;
    logic [1:0]      in_wb_sel;
    logic [XLEN-1:0] in_alu_res;
    logic [XLEN-1:0] in_csr_rdata;
    logic            mem_valid;
    logic [XLEN-1:0] mem_rd_data;
    logic            rf_wen;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            retire_valid;
    logic [XLEN-1:0] retire_pc;
    logic            err_timeout;
    logic [63:0]     retire_cnt;

    modport master (
        output in_valid, in_pc, in_rd, in_rd_wen, in_wb_sel, in_alu_res, in_csr_rdata,
               mem_valid, mem_rd_data,
        input  in_ready, rf_wen, rf_waddr, rf_wdata, retire_valid, retire_pc, err_timeout,
               retire_cnt
    );

    modport slave (
        input  in_valid, in_pc, in_rd, in_rd_wen, in_wb_sel, in_alu_res, in_csr_rdata,
               mem_valid, mem_rd_data,
        output in_ready, rf_wen, rf_waddr, rf_wdata, retire_valid, retire_pc, err_timeout,
               retire_cnt
    );
endinterface

// File: rtl/ysyx_23060240_wbu.sv
// NPC write-back stage: accepts one instruction, waits for load data if needed, commits one
// register-file write plus retire pulse. Define YSYX_23060240_WBU_RETIRE_CNT_EN for retire_cnt.
module ysyx_23060240_wbu #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input logic                 clk,
    input logic                 rst,
    ysyx_23060240_wbu_if.slave  bus
);
    localparam logic [1:0] StIdle    = 2'd0;
    localparam logic [1:0] StWaitMem = 2'd1;
    localparam logic [1:0] StCommit  = 2'd2;

    localparam logic [1:0]  SelMem   = 2'b01;
    localparam logic [1:0]  SelPc4   = 2'b10;
    localparam logic [1:0]  SelCsr   = 2'b11;
    localparam logic [15:0] WdogLast = 16'(TIMEOUT - 1);

    logic [1:0]      state_q, state_d;
    logic [15:0]     wdog_q, wdog_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [4:0]      rd_q, rd_d;
    logic            rd_wen_q, rd_wen_d;
    logic            err_q, err_d;
    logic            rf_wen_q, rf_wen_d;
    logic            retire_valid_q, retire_valid_d;
    logic [4:0]      rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic [XLEN-1:0] retire_pc_q, retire_pc_d;

    logic            in_ready;
    logic            accept;
    logic            commit_now;
    logic [XLEN-1:0] c_pc;
    logic [4:0]      c_rd;
    logic            c_wen;
    logic [XLEN-1:0] c_data;

    assign in_ready = (state_q != StWaitMem);
    assign accept   = bus.in_valid && in_ready;

    always_comb begin
        state_d    = state_q;
        wdog_d     = wdog_q;
        pc_d       = pc_q;
        rd_d       = rd_q;
        rd_wen_d   = rd_wen_q;
        err_d      = err_q;
        commit_now = 1'b0;
        c_pc       = '0;
        c_rd       = '0;
        c_wen      = 1'b0;
        c_data     = '0;
        case (state_q)
            StIdle, StCommit: begin
                state_d = StIdle;
                if (accept) begin
                    if (bus.in_wb_sel == SelMem) begin
                        state_d  = StWaitMem;
                        wdog_d   = '0;
                        pc_d     = bus.in_pc;
                        rd_d     = bus.in_rd;
                        rd_wen_d = bus.in_rd_wen;
                    end else begin
                        state_d    = StCommit;
                        commit_now = 1'b1;
                        c_pc       = bus.in_pc;
                        c_rd       = bus.in_rd;
                        c_wen      = bus.in_rd_wen;
                        case (bus.in_wb_sel)
                            SelPc4:  c_data = bus.in_pc + XLEN'(4);
                            SelCsr:  c_data = bus.in_csr_rdata;
                            default: c_data = bus.in_alu_res;
                        endcase
                    end
                end
            end
            StWaitMem: begin
                wdog_d = wdog_q + 16'd1;
                c_pc   = pc_q;
                c_rd   = rd_q;
                c_wen  = rd_wen_q;
                // Load data arriving on the timeout cycle still wins over the watchdog.
                if (bus.mem_valid) begin
                    state_d    = StCommit;
                    commit_now = 1'b1;
                    c_data     = bus.mem_rd_data;
                end else if (wdog_q == WdogLast) begin
                    state_d    = StCommit;
                    commit_now = 1'b1;
                    err_d      = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        rf_wen_d       = commit_now && c_wen && (c_rd != 5'd0);
        retire_valid_d = commit_now;
        rf_waddr_d     = commit_now ? c_rd : rf_waddr_q;
        rf_wdata_d     = commit_now ? c_data : rf_wdata_q;
        retire_pc_d    = commit_now ? c_pc : retire_pc_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= StIdle;
            wdog_q         <= '0;
            pc_q           <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            err_q          <= 1'b0;
            rf_wen_q       <= 1'b0;
            retire_valid_q <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_pc_q    <= '0;
        end else begin
            state_q        <= state_d;
            wdog_q         <= wdog_d;
            pc_q           <= pc_d;
            rd_q           <= rd_d;
            rd_wen_q       <= rd_wen_d;
            err_q          <= err_d;
            rf_wen_q       <= rf_wen_d;
            retire_valid_q <= retire_valid_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_pc_q    <= retire_pc_d;
        end
    end

`ifdef YSYX_23060240_WBU_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            retire_cnt_q <= '0;
        end else if (retire_valid_q) begin
            retire_cnt_q <= retire_cnt_q + 64'd1;
        end
    end

    assign bus.retire_cnt = retire_cnt_q;
`else
    assign bus.retire_cnt = '0;
`endif

    assign bus.in_ready     = in_ready;
    assign bus.rf_wen       = rf_wen_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.retire_valid = retire_valid_q;
    assign bus.retire_pc    = retire_pc_q;
    assign bus.err_timeout  = err_q;
endmodule

// File: tb/tb_ysyx_23060240_wbu.sv
// Randomized bench for the write-back stage: a transaction-level model predicts every retire,
// and a per-cycle monitor compares DUT outputs against it.
module tb_ysyx_23060240_wbu;
    localparam int unsigned XLEN = 32;
    localparam int unsigned TO   = 4;

    logic clk = 1'b0;
    logic rst;

    ysyx_23060240_wbu_if #(.XLEN(XLEN)) bus ();

    ysyx_23060240_wbu #(.XLEN(XLEN), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic        rfw;
        logic [31:0] data;
    } exp_t;

    exp_t        expq[$];
    int          n_chk  = 0;
    int          n_fail = 0;
    logic        err_exp = 1'b0;
    logic [63:0] cnt_exp = '0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] cnt_ref(input logic [63:0] c);
`ifdef YSYX_23060240_WBU_RETIRE_CNT_EN
        return c;
`else
        return 64'd0;
`endif
    endfunction

    // Per-cycle monitor: every retire must match the head of the expectation queue.
    always @(posedge clk) begin
        #1;
        if (rst) begin
            cnt_exp = '0;
        end else begin
            check("retire_cnt", bus.retire_cnt, cnt_ref(cnt_exp));
            check("err_timeout", {63'd0, bus.err_timeout}, {63'd0, err_exp});
            if (bus.retire_valid) begin
                if (expq.size() == 0) begin
                    check("unexpected retire", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = expq.pop_front();
                    check("retire_pc", {32'd0, bus.retire_pc}, {32'd0, e.pc});
                    check("rf_waddr", {59'd0, bus.rf_waddr}, {59'd0, e.rd});
                    check("rf_wdata", {32'd0, bus.rf_wdata}, {32'd0, e.data});
                    check("rf_wen", {63'd0, bus.rf_wen}, {63'd0, e.rfw});
                end
                cnt_exp = cnt_exp + 64'd1;
            end else begin
                check("rf_wen idle", {63'd0, bus.rf_wen}, 64'd0);
            end
        end
    end

    // Called at a negedge; returns at the negedge of the commit cycle.
    task automatic send(input logic [31:0] pc, input logic [4:0] rd, input logic wen,
                        input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] csr,
                        input int delay, input logic [31:0] mdata);
        int   guard;
        int   kend;
        exp_t e;
        bus.in_valid     = 1'b1;
        bus.in_pc        = pc;
        bus.in_rd        = rd;
        bus.in_rd_wen    = wen;
        bus.in_wb_sel    = sel;
        bus.in_alu_res   = alu;
        bus.in_csr_rdata = csr;
        // A stray load pulse in the transfer cycle must be ignored.
        if (sel == 2'b01 && $urandom_range(0, 1) == 1) begin
            bus.mem_valid   = 1'b1;
            bus.mem_rd_data = $urandom;
        end
        guard = 0;
        while (!bus.in_ready) begin
            @(negedge clk);
            guard++;
            if (guard > 50) begin
                check("in_ready bound", 64'd0, 64'd1);
                bus.in_valid = 1'b0;
                return;
            end
        end
        e.pc  = pc;
        e.rd  = rd;
        e.rfw = wen && (rd != 5'd0);
        if (sel != 2'b01) begin
            case (sel)
                2'b00:   e.data = alu;
                2'b10:   e.data = pc + 32'd4;
                default: e.data = csr;
            endcase
            expq.push_back(e);
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.mem_valid = 1'b0;
        end else begin
            @(negedge clk);
            bus.in_valid  = 1'b0;
            bus.mem_valid = 1'b0;
            kend = (delay <= int'(TO)) ? delay : int'(TO);
            for (int k = 1; k <= kend; k++) begin
                check("in_ready during wait", {63'd0, bus.in_ready}, 64'd0);
                if (k == delay) begin
                    bus.mem_valid   = 1'b1;
                    bus.mem_rd_data = mdata;
                end else begin
                    bus.mem_valid   = 1'b0;
                    bus.mem_rd_data = $urandom;
                end
                if (k == kend) begin
                    e.data = (delay <= int'(TO)) ? mdata : 32'd0;
                    expq.push_back(e);
                    if (delay > int'(TO)) err_exp = 1'b1;
                end
                @(negedge clk);
            end
            bus.mem_valid = 1'b0;
        end
        check("retire latency", {63'd0, bus.retire_valid}, 64'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        err_exp = 1'b0;
        expq.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        bus.in_valid     = 1'b0;
        bus.in_pc        = '0;
        bus.in_rd        = '0;
        bus.in_rd_wen    = 1'b0;
        bus.in_wb_sel    = '0;
        bus.in_alu_res   = '0;
        bus.in_csr_rdata = '0;
        bus.mem_valid    = 1'b0;
        bus.mem_rd_data  = '0;
        #12;
        check("reset in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("reset rf_wen", {63'd0, bus.rf_wen}, 64'd0);
        check("reset retire_valid", {63'd0, bus.retire_valid}, 64'd0);
        check("reset err_timeout", {63'd0, bus.err_timeout}, 64'd0);
        check("reset rf_waddr", {59'd0, bus.rf_waddr}, 64'd0);
        check("reset rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
        check("reset retire_pc", {32'd0, bus.retire_pc}, 64'd0);
        check("reset retire_cnt", bus.retire_cnt, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // ALU write
        send(32'h8000_0000, 5'd5, 1'b1, 2'b00, 32'h1234, 32'h0, 0, 32'h0);
        check("alu rf_wen", {63'd0, bus.rf_wen}, 64'd1);
        check("alu rf_waddr", {59'd0, bus.rf_waddr}, 64'd5);
        check("alu rf_wdata", {32'd0, bus.rf_wdata}, 64'h1234);
        check("alu retire_pc", {32'd0, bus.retire_pc}, 64'h8000_0000);

        // Load returning three cycles after transfer
        send(32'h8000_0004, 5'd7, 1'b1, 2'b01, 32'hdead, 32'h0, 3, 32'hFFFF_FF80);
        check("load rf_wdata", {32'd0, bus.rf_wdata}, 64'hFFFF_FF80);
        check("load rf_waddr", {59'd0, bus.rf_waddr}, 64'd7);

        // PC+4 wraps
        send(32'hFFFF_FFFC, 5'd1, 1'b1, 2'b10, 32'h5555, 32'h0, 0, 32'h0);
        check("pc4 wrap rf_wdata", {32'd0, bus.rf_wdata}, 64'h0);

        // Write to x0 retires without a write
        send(32'h8000_0010, 5'd0, 1'b1, 2'b00, 32'h77, 32'h0, 0, 32'h0);
        check("x0 rf_wen", {63'd0, bus.rf_wen}, 64'd0);
        check("x0 retire_valid", {63'd0, bus.retire_valid}, 64'd1);

        // Ten back-to-back ALU ops from a fresh counter
        do_reset();
        for (int i = 0; i < 10; i++) begin
            send(32'h100 + 32'(i * 4), 5'(i + 1), 1'b1, 2'b00, 32'(i * 3), 32'h0, 0, 32'h0);
        end
        @(negedge clk);
        check("retire_cnt after 10", bus.retire_cnt, cnt_ref(64'd10));

        // Load timeout: data 0, sticky error
        send(32'h200, 5'd9, 1'b1, 2'b01, 32'h0, 32'h0, 99, 32'hAAAA_AAAA);
        check("timeout err", {63'd0, bus.err_timeout}, 64'd1);
        check("timeout rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
        send(32'h204, 5'd10, 1'b1, 2'b11, 32'h0, 32'hC5C5, 0, 32'h0);
        check("timeout sticky", {63'd0, bus.err_timeout}, 64'd1);
        check("csr rf_wdata", {32'd0, bus.rf_wdata}, 64'hC5C5);

        // Randomized mix
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] pc;
            pc = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            send(pc, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom_range(1, 6), $urandom);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        @(negedge clk);

        // Reset while waiting for load data drops the instruction
        bus.in_valid  = 1'b1;
        bus.in_wb_sel = 2'b01;
        bus.in_rd     = 5'd3;
        bus.in_rd_wen = 1'b1;
        bus.in_pc     = 32'h300;
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("wait in_ready", {63'd0, bus.in_ready}, 64'd0);
        #2;
        rst = 1'b1;
        err_exp = 1'b0;
        #1;
        check("async rst in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("async rst retire_valid", {63'd0, bus.retire_valid}, 64'd0);
        check("async rst rf_wdata", {32'd0, bus.rf_wdata}, 64'd0);
        check("async rst err", {63'd0, bus.err_timeout}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.mem_valid   = 1'b1;
        bus.mem_rd_data = 32'h1111_2222;
        @(negedge clk);
        bus.mem_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("no retire after rst", {63'd0, bus.retire_valid}, 64'd0);
            @(negedge clk);
        end

        check("queue drained", 64'(expq.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
